// File: rtl/aggregate_output_collector.sv
`default_nettype none
// ============================================================================
// Module      : aggregate_output_collector
// Description : Collects result beats from the activation/bias/accumulate
//               stage into a small FIFO and writes them to result memory at
//               consecutive addresses. A transaction expects `count` beats,
//               then drains the FIFO and signals `done` for one cycle.
// Ports       : clk, rst (async, active high)
//               start, base_addr, count      - transaction request
//               output_valid, output_values,
//               overflow                     - incoming result beats
//               wr_en, wr_addr, wr_data,
//               wr_ready                     - result memory write port
//               busy, done                   - transaction status
//               err_overflow, err_drop       - sticky per-transaction errors
// Revision    : 1.0 - initial release
// ============================================================================
module aggregate_output_collector #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        count,
    input  logic              output_valid,
    input  logic [63:0]       output_values,
    input  logic              overflow,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [63:0]       wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic              err_drop
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              r_state;
    logic [63:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W:0]    r_occ;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_count;
    logic [7:0]          r_rcv;
    logic                r_err_ovf;
    logic                r_err_drop;

    logic                w_active;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_beat;
    logic                w_push;
    logic [7:0]          w_rcv_next;

    assign w_active   = (r_state == S_COLLECT) || (r_state == S_DRAIN);
    assign w_empty    = (r_occ == '0);
    assign w_full     = (r_occ == (c_PTR_W+1)'(DEPTH));
    assign w_pop      = w_active && !w_empty && wr_ready;
    assign w_beat     = (r_state == S_COLLECT) && output_valid;
    // A full FIFO can still take a beat when the head leaves on the same edge.
    assign w_push     = w_beat && (!w_full || w_pop);
    assign w_rcv_next = r_rcv + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_addr     <= '0;
            r_count    <= '0;
            r_rcv      <= '0;
            r_err_ovf  <= 1'b0;
            r_err_drop <= 1'b0;
            // Cleared so wr_data reads zero while reset is held.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            // FIFO storage and pointers
            if (w_push) begin
                r_mem[r_wr_ptr] <= output_values;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_addr   <= r_addr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase

            // Transaction control
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr     <= base_addr;
                        r_count    <= count;
                        r_rcv      <= '0;
                        r_err_ovf  <= 1'b0;
                        r_err_drop <= 1'b0;
                        r_state    <= (count == 8'd0) ? S_DONE : S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (output_valid) begin
                        r_rcv <= w_rcv_next;
                        if (overflow) begin
                            r_err_ovf <= 1'b1;
                        end
                        if (!w_push) begin
                            r_err_drop <= 1'b1;
                        end
                        if (w_rcv_next == r_count) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // No pushes here, so a pop at occupancy one empties it.
                    if (w_empty || (w_pop && (r_occ == (c_PTR_W+1)'(1)))) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wr_en        = w_active && !w_empty;
    assign wr_addr      = r_addr;
    assign wr_data      = r_mem[r_rd_ptr];
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign err_overflow = r_err_ovf;
    assign err_drop     = r_err_drop;

endmodule
`default_nettype wire

// File: tb/tb_aggregate_output_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_aggregate_output_collector
// Description : Self-checking bench for aggregate_output_collector. A queue
//               based reference model predicts every output each cycle;
//               directed scenarios plus randomized transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aggregate_output_collector;

    localparam int c_DEPTH  = 4;
    localparam int c_ADDR_W = 10;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [c_ADDR_W-1:0] base_addr = '0;
    logic [7:0]          count = '0;
    logic                output_valid = 1'b0;
    logic [63:0]         output_values = '0;
    logic                overflow = 1'b0;
    logic                wr_en;
    logic [c_ADDR_W-1:0] wr_addr;
    logic [63:0]         wr_data;
    logic                wr_ready = 1'b0;
    logic                busy;
    logic                done;
    logic                err_overflow;
    logic                err_drop;

    aggregate_output_collector #(
        .DEPTH  (c_DEPTH),
        .ADDR_W (c_ADDR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .count         (count),
        .output_valid  (output_valid),
        .output_values (output_values),
        .overflow      (overflow),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .busy          (busy),
        .done          (done),
        .err_overflow  (err_overflow),
        .err_drop      (err_drop)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int n_done  = 0;

    // Writes observed at the memory port: address and data kept separately.
    logic [c_ADDR_W-1:0] log_addr[$];
    logic [63:0]         log_data[$];

    // Reference model
    typedef enum {P_IDLE, P_COLLECT, P_DRAIN, P_DONE} phase_t;
    phase_t              m_phase = P_IDLE;
    logic [63:0]         mq[$];
    logic [c_ADDR_W-1:0] m_addr = '0;
    int                  m_cnt  = 0;
    int                  m_rcv  = 0;
    bit                  m_ovf  = 1'b0;
    bit                  m_drop = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        mq.delete();
        m_addr = '0;
        m_cnt  = 0;
        m_rcv  = 0;
        m_ovf  = 1'b0;
        m_drop = 1'b0;
    endtask

    // One clock: check outputs against the model, drive inputs for the
    // coming rising edge, then advance the model across that edge.
    task automatic cycle(input bit s, input logic [c_ADDR_W-1:0] ba, input logic [7:0] c,
                         input bit v, input logic [63:0] d, input bit o, input bit rdy);
        bit exp_en;
        bit pop;
        @(negedge clk);
        exp_en = ((m_phase == P_COLLECT) || (m_phase == P_DRAIN)) && (mq.size() > 0);
        chk("busy", busy, m_phase != P_IDLE);
        chk("done", done, m_phase == P_DONE);
        chk("wr_en", wr_en, exp_en);
        chk("wr_addr", wr_addr, m_addr);
        if (exp_en) chk("wr_data", wr_data, mq[0]);
        chk("err_overflow", err_overflow, m_ovf);
        chk("err_drop", err_drop, m_drop);
        if (done === 1'b1) n_done++;

        start = s; base_addr = ba; count = c;
        output_valid = v; output_values = d; overflow = o; wr_ready = rdy;
        if (wr_en === 1'b1 && rdy) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end

        pop = exp_en && rdy;
        case (m_phase)
            P_IDLE: if (s) begin
                m_addr  = ba;
                m_cnt   = c;
                m_rcv   = 0;
                m_ovf   = 1'b0;
                m_drop  = 1'b0;
                m_phase = (c == 0) ? P_DONE : P_COLLECT;
            end
            P_COLLECT: begin
                if (pop) begin
                    void'(mq.pop_front());
                    m_addr++;
                end
                if (v) begin
                    m_rcv++;
                    if (o) m_ovf = 1'b1;
                    if (mq.size() < c_DEPTH) mq.push_back(d);
                    else m_drop = 1'b1;
                    if (m_rcv == m_cnt) m_phase = P_DRAIN;
                end
            end
            P_DRAIN: begin
                if (pop) begin
                    void'(mq.pop_front());
                    m_addr++;
                end
                if (mq.size() == 0) m_phase = P_DONE;
            end
            P_DONE: m_phase = P_IDLE;
        endcase
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, '0, 0, rdy);
    endtask

    task automatic beat(input logic [63:0] d, input bit o, input bit rdy);
        cycle(0, '0, '0, 1, d, o, rdy);
    endtask

    // Asserts reset away from the clock edge and checks outputs clear at once.
    task automatic do_reset();
        @(negedge clk);
        start = 1'b0; output_valid = 1'b0; overflow = 1'b0; wr_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_ovf", err_overflow, 0);
        chk("rst_err_drop", err_drop, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        log_addr.delete();
        log_data.delete();
        n_done = 0;
    endtask

    initial begin
        do_reset();

        // Three back-to-back beats, memory always ready.
        clear_logs();
        cycle(1, 10'h010, 8'd3, 0, '0, 0, 1);
        beat(64'hA, 0, 1);
        beat(64'hB, 0, 1);
        beat(64'hC, 0, 1);
        idle(6, 1);
        chk("basic_nwr", log_addr.size(), 3);
        if (log_addr.size() == 3) begin
            chk("basic_a0", log_addr[0], 10'h010);
            chk("basic_d0", log_data[0], 64'hA);
            chk("basic_a1", log_addr[1], 10'h011);
            chk("basic_d1", log_data[1], 64'hB);
            chk("basic_a2", log_addr[2], 10'h012);
            chk("basic_d2", log_data[2], 64'hC);
        end
        chk("basic_ndone", n_done, 1);
        chk("basic_ovf", err_overflow, 0);
        chk("basic_drop", err_drop, 0);

        // Memory stalled while six beats arrive into a four-deep FIFO.
        clear_logs();
        cycle(1, 10'h100, 8'd6, 0, '0, 0, 0);
        for (int i = 0; i < 6; i++) beat(64'h100 + i, 0, 0);
        idle(1, 0);
        idle(10, 1);
        chk("full_nwr", log_addr.size(), 4);
        for (int i = 0; i < 4 && i < log_data.size(); i++)
            chk("full_data", log_data[i], 64'h100 + i);
        chk("full_drop", err_drop, 1);
        chk("full_ndone", n_done, 1);

        // Address wraps at the top of the address space.
        clear_logs();
        cycle(1, 10'h3FF, 8'd2, 0, '0, 0, 1);
        beat(64'h11, 0, 1);
        beat(64'h22, 0, 1);
        idle(5, 1);
        chk("wrap_nwr", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            chk("wrap_a0", log_addr[0], 10'h3FF);
            chk("wrap_a1", log_addr[1], 10'h000);
        end

        // Overflow on the second beat; cleared by the next accepted start.
        clear_logs();
        cycle(1, 10'h020, 8'd2, 0, '0, 0, 1);
        beat(64'h1, 0, 1);
        beat(64'h2, 1, 1);
        idle(5, 1);
        chk("ovf_set", err_overflow, 1);
        cycle(1, 10'h030, 8'd1, 0, '0, 0, 1);
        idle(1, 1);
        chk("ovf_clr", err_overflow, 0);
        beat(64'h3, 0, 1);
        idle(5, 1);

        // Zero-length transaction.
        clear_logs();
        cycle(1, 10'h040, 8'd0, 0, '0, 0, 1);
        idle(4, 1);
        chk("zero_ndone", n_done, 1);
        chk("zero_nwr", log_addr.size(), 0);

        // Reset in the middle of a transaction.
        clear_logs();
        cycle(1, 10'h050, 8'd4, 0, '0, 0, 0);
        beat(64'h5, 0, 0);
        beat(64'h6, 0, 0);
        idle(1, 0);
        do_reset();
        idle(10, 1);
        chk("rst_nwr", log_addr.size(), 0);
        chk("rst_ndone", n_done, 0);

        // Randomized transactions, including stray starts and beats.
        for (int t = 0; t < 40; t++) begin
            int guard;
            idle($urandom_range(0, 2), $urandom_range(0, 1));
            cycle(0, '0, '0, 1, {$urandom, $urandom}, 1, 1);
            cycle(1, c_ADDR_W'($urandom), 8'($urandom_range(0, 12)), 0, '0, 0,
                  $urandom_range(0, 1));
            guard = 0;
            while (m_phase != P_IDLE && guard < 400) begin
                cycle(($urandom % 8) == 0, c_ADDR_W'($urandom), 8'($urandom),
                      ($urandom % 100) < 60, {$urandom, $urandom},
                      ($urandom % 10) == 0, ($urandom % 100) < 50);
                guard++;
            end
            chk("rand_timeout", m_phase == P_IDLE, 1);
        end
        idle(3, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aggregate_output_collector.md
AGGREGATE_OUTPUT_COLLECTOR -- requirements
Module: aggregate_output_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO depth in 64-bit words; power of two, 2..16.
REQ-002 SHALL have parameter ADDR_W, default 10, width of the write address.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a collection transaction.
REQ-006 SHALL have port base_addr  input  ADDR_W  first write address, latched on accepted start.
REQ-007 SHALL have port count  input  8  number of result beats expected, latched on accepted start.
REQ-008 SHALL have port output_valid  input  1  result beat valid, from the activation/bias/accumulate stage.
REQ-009 SHALL have port output_values  input  64  result beat data.
REQ-010 SHALL have port overflow  input  1  arithmetic overflow flag accompanying the beat.
REQ-011 SHALL have port wr_en  output  1  write request to result memory.
REQ-012 SHALL have port wr_addr  output  ADDR_W  write address.
REQ-013 SHALL have port wr_data  output  64  write data.
REQ-014 SHALL have port wr_ready  input  1  memory accepts the write this cycle.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at transaction end.
REQ-017 SHALL have port err_overflow  output  1  sticky; an accepted beat carried overflow=1.
REQ-018 SHALL have port err_drop  output  1  sticky; a beat was lost because the FIFO was full.

Function
REQ-019 SHALL implement states IDLE, COLLECT, DRAIN, DONE.
REQ-020 In IDLE, start=1 SHALL latch base_addr and count, clear the receive counter, err_overflow and err_drop, and go to COLLECT; if count=0, go to DONE instead.
REQ-021 start SHALL be ignored in any state other than IDLE.
REQ-022 In COLLECT, each cycle with output_valid=1 SHALL increment the receive counter by one, whether the beat is stored or dropped.
REQ-023 A beat SHALL be pushed if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
REQ-024 Otherwise the beat SHALL be discarded and err_drop set.
REQ-025 overflow=1 with output_valid=1 in COLLECT SHALL set err_overflow.
REQ-026 When the receive counter reaches the latched count, the FSM SHALL go to DRAIN on that edge.
REQ-027 output_valid SHALL be ignored (no push, no flags) in IDLE, DRAIN and DONE.
REQ-028 wr_en SHALL equal FIFO-not-empty in COLLECT and DRAIN, and 0 in IDLE and DONE.
REQ-029 wr_data SHALL equal the FIFO head, and SHALL hold stable with wr_addr while wr_en=1 and wr_ready=0.
REQ-030 wr_en=1 with wr_ready=1 SHALL pop the head and increment wr_addr, modulo 2^ADDR_W.
REQ-031 Latency SHALL be one cycle: a beat captured at edge N with an empty FIFO appears on wr_en/wr_data after edge N.
REQ-032 DRAIN SHALL go to DONE on the edge where the last FIFO entry is popped, or immediately if the FIFO is already empty.
REQ-033 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE; err flags SHALL persist until the next accepted start.
REQ-034 FIFO SHALL track full and empty with pointers plus occupancy count; simultaneous push and pop SHALL leave the count unchanged.

Reset
REQ-035 rst=1 SHALL asynchronously force IDLE, empty the FIFO, and zero the counters.
REQ-036 rst=1 SHALL asynchronously drive wr_en, wr_addr, wr_data, busy, done, err_overflow and err_drop to 0.
REQ-037 Reset asserted mid-transaction SHALL abandon it: no done pulse, and no further writes after release until a new start.

Verification
REQ-038 start, base_addr=0x010, count=3; beats 0xA, 0xB, 0xC back-to-back; wr_ready=1 -> writes (0x010,0xA), (0x011,0xB), (0x012,0xC); done pulses one cycle; both err flags 0.
REQ-039 DEPTH=4, count=6, wr_ready=0 for 8 cycles, 6 consecutive beats -> 4 stored; err_drop=1; after wr_ready=1, exactly 4 writes, then done.
REQ-040 base_addr=0x3FF, count=2 -> writes to 0x3FF then 0x000.
REQ-041 count=2; second beat with overflow=1 -> err_overflow=1 at done; cleared on the next start.
REQ-042 count=0 -> busy for 1 cycle, done pulse, no wr_en.
REQ-043 rst asserted after 2 of 4 beats -> all outputs 0 immediately; no done pulse; wr_en stays 0 after release.
